// File: rtl/fu_ctrl_seq.sv
// fu_ctrl_seq: two-cycle fetch/execute sequencer that drives a 4-bit function unit.
// Optional single-step mode (PAUSE state plus step input) is enabled by `CTRL_SINGLE_STEP_EN.
module fu_ctrl_seq #(
  parameter int N    = 4,
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            busy,
  output logic            halted,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [4:0]      fu_fs,
  output logic [N-1:0]    fu_a,
  output logic [N-1:0]    fu_b,
  input  logic [N-1:0]    fu_f,
  input  logic [3:0]      fu_flags,
  output logic [3:0]      flags
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  localparam logic [1:0] C_ALU  = 2'b00;
  localparam logic [1:0] C_LDI  = 2'b01;
  localparam logic [1:0] C_BR   = 2'b10;
  localparam logic [1:0] C_HALT = 2'b11;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [N-1:0]    rf [8];
  logic [3:0]      flags_q;

  // Program memory is synchronous: the word for imem_addr presented in FETCH
  // is on imem_data during the following EXEC cycle.
  logic [1:0]      cls;
  logic            br_taken;
  logic [PC_W-1:0] br_off;

  assign cls      = imem_data[15:14];
  assign br_taken = (flags_q[imem_data[13:12]] == imem_data[11]);
  assign br_off   = PC_W'($signed(imem_data[7:0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        case (cls)
          C_HALT: state_d = S_HALT;
          C_BR: begin
            pc_d = br_taken ? pc_q + br_off : pc_q + PC_W'(1);
`ifdef CTRL_SINGLE_STEP_EN
            state_d = S_PAUSE;
`else
            state_d = S_FETCH;
`endif
          end
          default: begin
            pc_d = pc_q + PC_W'(1);
`ifdef CTRL_SINGLE_STEP_EN
            state_d = S_PAUSE;
`else
            state_d = S_FETCH;
`endif
          end
        endcase
      end
`ifdef CTRL_SINGLE_STEP_EN
      S_PAUSE: if (step) state_d = S_FETCH;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Results land at the end of their own EXEC cycle, so the next fetch sees them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      flags_q <= '0;
    end else if (state_q == S_EXEC) begin
      case (cls)
        C_ALU: begin
          rf[imem_data[8:6]] <= fu_f;
          flags_q            <= fu_flags;
        end
        C_LDI:   rf[imem_data[13:11]] <= imem_data[N-1:0];
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted    = (state_q == S_HALT);
  assign imem_addr = pc_q;
  assign fu_fs     = ((state_q == S_EXEC) && (cls == C_ALU)) ? imem_data[13:9] : 5'd0;
  assign fu_a      = rf[imem_data[5:3]];
  assign fu_b      = rf[imem_data[2:0]];
  assign flags     = flags_q;

endmodule

// File: tb/tb_fu_ctrl_seq.sv
// Bench for fu_ctrl_seq: instruction-level reference model, per-cycle output compare,
// directed programs with literal expectations, then randomized programs.
module tb_fu_ctrl_seq;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
  logic        step  = 1'b0;
`endif
  logic        busy, halted;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [4:0]  fu_fs;
  logic [3:0]  fu_a, fu_b, fu_f, fu_flags, flags;

  logic [15:0] prog [256];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fu_ctrl_seq #(.N(4), .PC_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .busy(busy),
    .halted(halted),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .fu_fs(fu_fs),
    .fu_a(fu_a),
    .fu_b(fu_b),
    .fu_f(fu_f),
    .fu_flags(fu_flags),
    .flags(flags)
  );

  // Function unit: returns {V,N,Z,C, F}.
  function automatic logic [7:0] fu_calc(input logic [4:0] fs, input logic [3:0] a,
                                         input logic [3:0] b);
    logic [3:0] y, f;
    logic [4:0] s;
    logic v, c;
    y = 4'd0; f = 4'd0; s = 5'd0; v = 1'b0; c = 1'b0;
    case (fs[4:3])
      2'b00: begin
        case (fs[2:1])
          2'b00:   y = 4'd0;
          2'b01:   y = b;
          2'b10:   y = ~b;
          default: y = 4'hF;
        endcase
        s = {1'b0, a} + {1'b0, y} + {4'd0, fs[0]};
        f = s[3:0];
        c = s[4];
        v = (a[3] == y[3]) && (f[3] != a[3]);
      end
      2'b01: begin
        case (fs[2:1])
          2'b00:   f = a & b;
          2'b01:   f = a | b;
          2'b10:   f = a ^ b;
          default: f = ~a;
        endcase
      end
      2'b10: begin
        case (fs[2:1])
          2'b01:   f = b >> 1;
          2'b10:   f = b << 1;
          default: f = b;
        endcase
      end
      default: f = b;
    endcase
    return {v, f[3], (f == 4'd0), c, f};
  endfunction

  always_comb {fu_flags, fu_f} = fu_calc(fu_fs, fu_a, fu_b);

  always @(posedge clk) imem_data <= prog[imem_addr];

  // Reference model: phase 0 idle, 1 fetch, 2 execute, 3 halted, 4 paused.
  int          m_ph = 0;
  logic [7:0]  m_pc = 8'd0;
  logic [3:0]  m_r [8] = '{default: 4'd0};
  logic [3:0]  m_fl = 4'd0;
  logic [15:0] m_ins;
  logic [7:0]  m_res;
  int          m_off;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_pc = 8'd0; m_fl = 4'd0;
      for (int i = 0; i < 8; i++) m_r[i] = 4'd0;
    end else begin
      case (m_ph)
        0, 3: if (start) begin m_ph = 1; m_pc = 8'd0; end
        1: m_ph = 2;
        2: begin
          m_ins = prog[m_pc];
          if (m_ins[15:14] == 2'b11) m_ph = 3;
          else begin
            if (m_ins[15:14] == 2'b00) begin
              m_res = fu_calc(m_ins[13:9], m_r[m_ins[5:3]], m_r[m_ins[2:0]]);
              m_r[m_ins[8:6]] = m_res[3:0];
              m_fl = m_res[7:4];
              m_pc = m_pc + 8'd1;
            end else if (m_ins[15:14] == 2'b01) begin
              m_r[m_ins[13:11]] = m_ins[3:0];
              m_pc = m_pc + 8'd1;
            end else begin
              m_off = m_ins[7] ? int'(m_ins[7:0]) - 256 : int'(m_ins[7:0]);
              if (m_fl[m_ins[13:12]] == m_ins[11])
                m_pc = 8'((int'(m_pc) + m_off + 256) % 256);
              else
                m_pc = m_pc + 8'd1;
            end
`ifdef CTRL_SINGLE_STEP_EN
            m_ph = 4;
`else
            m_ph = 1;
`endif
          end
        end
`ifdef CTRL_SINGLE_STEP_EN
        4: if (step) m_ph = 1;
`endif
        default: m_ph = 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [15:0] c_ins;
  always @(negedge clk) begin
    c_ins = prog[m_pc];
    chk("busy", 32'(busy), 32'(m_ph == 1 || m_ph == 2));
    chk("halted", 32'(halted), 32'(m_ph == 3));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("flags", 32'(flags), 32'(m_fl));
    chk("fu_fs", 32'(fu_fs), (m_ph == 2 && c_ins[15:14] == 2'b00) ? 32'(c_ins[13:9]) : 32'd0);
    if (m_ph == 2) begin
      chk("fu_a", 32'(fu_a), 32'(m_r[c_ins[5:3]]));
      chk("fu_b", 32'(fu_b), 32'(m_r[c_ins[2:0]]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_ph(input int ph, input int pc, input string name);
    int k = 0;
    while (!(m_ph == ph && int'(m_pc) == pc) && k < 200) begin tick(); k++; end
    if (!(m_ph == ph && int'(m_pc) == pc)) begin
      n_tests++; n_fail++;
      $display("FAIL %s: timeout waiting phase %0d pc %0h (phase %0d pc %0h)", name, ph, pc,
               m_ph, m_pc);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
  endtask

  task automatic do_reset();
    tick(); #3 rst_n = 1'b0; tick(); #3 rst_n = 1'b1; tick();
  endtask

  initial begin
    clear_prog();
    #1 rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_fs", 32'(fu_fs), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    #3 rst_n = 1'b1;
    tick();
`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b1; tick(); step = 1'b0;
    chk("step_idle_busy", 32'(busy), 32'd0);
    prog[0] = 16'h4805; prog[1] = 16'hC000;
    pulse_start(); tick(); tick();
    chk("pause_busy", 32'(busy), 32'd0);
    chk("pause_pc", 32'(imem_addr), 32'd1);
    repeat (3) tick();
    pulse_start();
    chk("pause_start_ignored", 32'(busy), 32'd0);
    step = 1'b1; tick(); step = 1'b0;
    chk("step_fetch_busy", 32'(busy), 32'd1);
    chk("step_fetch_addr", 32'(imem_addr), 32'd1);
    wait_ph(3, 1, "step_halt");
    step = 1'b1;
`endif
    // Program A: loads, add, subtract, taken and not-taken branch, halt.
    clear_prog();
    prog[0] = 16'h4805; prog[1] = 16'h5003; prog[2] = 16'h04CA; prog[3] = 16'h4807;
    prog[4] = 16'h0B09; prog[5] = 16'h9803; prog[8] = 16'h9003; prog[9] = 16'hC000;
    pulse_start();
    wait_ph(2, 2, "a_exec2");
    chk("add_fs", 32'(fu_fs), 32'h02);
    chk("add_a", 32'(fu_a), 32'd5);
    chk("add_b", 32'(fu_b), 32'd3);
    wait_ph(1, 3, "a_fetch3");
    chk("add_flags", 32'(flags), 32'hC);
    pulse_start();
    chk("start_in_fetch_busy", 32'(busy), 32'd1);
    chk("start_in_fetch_addr", 32'(imem_addr), 32'd3);
    chk("ldi_fs_zero", 32'(fu_fs), 32'd0);
    wait_ph(1, 5, "a_fetch5");
    chk("sub_flags", 32'(flags), 32'h3);
    wait_ph(1, 8, "a_br_taken");
    chk("br_taken_addr", 32'(imem_addr), 32'd8);
    wait_ph(1, 9, "a_br_not_taken");
    chk("br_not_taken_addr", 32'(imem_addr), 32'd9);
    wait_ph(3, 9, "a_halt");
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    tick();
    chk("halt_pc_hold", 32'(imem_addr), 32'd9);
    pulse_start();
    chk("restart_addr", 32'(imem_addr), 32'd0);
    chk("restart_halted", 32'(halted), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    // Asynchronous reset in the middle of the ALU instruction.
    wait_ph(2, 2, "a_exec2_again");
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_addr", 32'(imem_addr), 32'd0);
    chk("midrst_flags", 32'(flags), 32'd0);
    chk("midrst_fs", 32'(fu_fs), 32'd0);
    tick(); #3 rst_n = 1'b1; tick();
    clear_prog();
    prog[0] = 16'h01DB; prog[1] = 16'hC000;
    pulse_start();
    wait_ph(2, 0, "z_exec0");
    chk("r3_after_reset", 32'(fu_a), 32'd0);
    wait_ph(3, 1, "z_halt");
    chk("pass_a_flags", 32'(flags), 32'h2);
    // Program B: backward branch wrapping below zero, forward wrapping past 0xFF.
    clear_prog();
    prog[0] = 16'h4000; prog[1] = 16'h80FE; prog[255] = 16'h8003; prog[2] = 16'hC000;
    pulse_start();
    wait_ph(1, 255, "b_wrap_back");
    chk("wrap_back_addr", 32'(imem_addr), 32'hFF);
    wait_ph(1, 2, "b_wrap_fwd");
    chk("wrap_fwd_addr", 32'(imem_addr), 32'h02);
    wait_ph(3, 2, "b_halt");
    chk("b_halted", 32'(halted), 32'd1);
    clear_prog();
    prog[0] = 16'h8000;
    pulse_start();
    repeat (12) tick();
    chk("self_loop_addr", 32'(imem_addr), 32'd0);
    chk("self_loop_not_halted", 32'(halted), 32'd0);
    do_reset();
    // Random programs with random start (and step) activity.
    for (int run = 0; run < 24; run++) begin
      for (int i = 0; i < 256; i++) begin
        case ($urandom_range(0, 31))
          0:                      prog[i] = {2'b11, 14'($urandom)};
          1,2,3,4,5,6,7,8,9,10,11: prog[i] = {2'b00, 14'($urandom)};
          12,13,14,15,16,17,18,19: prog[i] = {2'b01, 14'($urandom)};
          default:                prog[i] = {2'b10, 14'($urandom)};
        endcase
      end
      pulse_start();
      for (int cyc = 0; cyc < 300; cyc++) begin
        start = ($urandom_range(0, 15) == 0);
`ifdef CTRL_SINGLE_STEP_EN
        step = ($urandom_range(0, 2) == 0);
`endif
        tick();
      end
      start = 1'b0;
      do_reset();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
